// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode/format encodings, sequencer state type and opcode helpers.
package isa_pkg;

  localparam logic [3:0] OP_LB   = 4'b0000;
  localparam logic [3:0] OP_SB   = 4'b0001;
  localparam logic [3:0] OP_JMP  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_BNE  = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1110;
  localparam logic [3:0] OP_BLS  = 4'b1111;

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_J = 2'b10;
  localparam logic [1:0] FMT_B = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } seq_state_t;

  function automatic logic is_branch_op(input logic [3:0] opcode);
    return (opcode == OP_BNE) || (opcode == OP_BEQ) || (opcode == OP_BLT) ||
           (opcode == OP_BLS);
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-pc priority mux: stall > halt > jump > taken branch > sequential.
module next_pc_sel
  import isa_pkg::*;
#(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned PC_STEP = 1
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            stall_i,
  input  logic [3:0]      opcode_i,
  input  logic [PC_W-1:0] jmp_loc_i,
  input  logic            branch_taken_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic            halt_o
);

  localparam logic [PC_W-1:0] Step = PC_W'(PC_STEP);

  always_comb begin
    next_pc_o = pc_i + Step;
    halt_o    = 1'b0;
    if (stall_i) begin
      next_pc_o = pc_i;
    end else begin
      // Unknown or unmapped opcodes fall through to the sequential path.
      case (opcode_i)
        OP_HALT: begin
          next_pc_o = pc_i;
          halt_o    = 1'b1;
        end
        OP_JMP:  next_pc_o = jmp_loc_i;
        default: begin
          if (is_branch_op(opcode_i) && branch_taken_i) next_pc_o = jmp_loc_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run/halt control for the fetch stage, with a saturating retire counter.
module pc_sequencer
  import isa_pkg::*;
#(
  parameter int unsigned     PC_W       = 16,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int unsigned     PC_STEP    = 1,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic [3:0]       opcode_i,
  input  logic [PC_W-1:0]  jmp_loc_i,
  input  logic             branch_taken_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] instr_count_o
);

  seq_state_t       state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [PC_W-1:0]  next_pc;
  logic             halt;
  logic [CNT_W-1:0] cnt_inc;

  next_pc_sel #(
    .PC_W    (PC_W),
    .PC_STEP (PC_STEP)
  ) u_next_pc_sel (
    .pc_i           (pc_q),
    .stall_i        (stall_i),
    .opcode_i       (opcode_i),
    .jmp_loc_i      (jmp_loc_i),
    .branch_taken_i (branch_taken_i),
    .next_pc_o      (next_pc),
    .halt_o         (halt)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StHalted: begin
          if (start_i) begin
            state_q <= StRun;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StRun: begin
          if (!stall_i) begin
            pc_q  <= next_pc;
            cnt_q <= cnt_inc;
            if (halt) begin
              state_q <= StHalted;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign instr_count_o = cnt_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
